// File: rtl/sd_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sd_reg_arbiter
// Purpose  : Two-requester arbiter for the shared SD register port. Fixed
//            priority (r0 over r1) by default; defining SD_ARB_RR_EN selects
//            round-robin arbitration instead.
// Revision : 1.0 - initial release
// ============================================================================
module sd_reg_arbiter #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r0_req,
  input  logic       r1_req,
  input  logic       r0_we,
  input  logic       r1_we,
  input  logic [6:0] r0_addr,
  input  logic [6:0] r1_addr,
  input  logic [7:0] r0_wdata,
  input  logic [7:0] r1_wdata,
  output logic       r0_ack,
  output logic       r1_ack,
  output logic [7:0] r0_rdata,
  output logic [7:0] r1_rdata,
  output logic [6:0] sd_addr,
  output logic       sd_we,
  output logic [7:0] sd_data_o,
  input  logic [7:0] sd_data_i,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  localparam logic [3:0] C_LAT_LAST = 4'(READ_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sel_q, sel_d;
  logic [6:0] sd_addr_q, sd_addr_d;
  logic       sd_we_q, sd_we_d;
  logic [7:0] sd_data_q, sd_data_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic [7:0] rdata0_q, rdata0_d;
  logic [7:0] rdata1_q, rdata1_d;
  logic       busy_q, busy_d;

  logic       any_req;
  logic       pick_r1;
  logic       win_we;
  logic [6:0] win_addr;
  logic [7:0] win_wdata;

  assign any_req   = r0_req | r1_req;
  assign win_we    = pick_r1 ? r1_we    : r0_we;
  assign win_addr  = pick_r1 ? r1_addr  : r0_addr;
  assign win_wdata = pick_r1 ? r1_wdata : r0_wdata;

`ifdef SD_ARB_RR_EN
  logic last_grant_q;
  logic last_grant_d;

  // On contention the requester that was not served last takes the grant.
  assign pick_r1 = r1_req & (~r0_req | ~last_grant_q);

  always_comb begin
    last_grant_d = last_grant_q;
    if ((state_q == ST_IDLE) && any_req) begin
      last_grant_d = pick_r1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign pick_r1 = r1_req & ~r0_req;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    sd_addr_d = sd_addr_q;
    sd_we_d   = 1'b0;
    sd_data_d = sd_data_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (any_req) begin
          sel_d     = pick_r1;
          sd_addr_d = win_addr;
          if (win_we) begin
            // Strobe and ack are launched together so both land in the
            // single WRITE cycle.
            sd_data_d = win_wdata;
            sd_we_d   = 1'b1;
            ack0_d    = ~pick_r1;
            ack1_d    = pick_r1;
            state_d   = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end

      ST_WRITE: begin
        state_d = ST_IDLE;
      end

      ST_READ: begin
        if (ack0_q || ack1_q) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == C_LAT_LAST) begin
            if (sel_q) begin
              rdata1_d = sd_data_i;
              ack1_d   = 1'b1;
            end else begin
              rdata0_d = sd_data_i;
              ack0_d   = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      sd_addr_q <= '0;
      sd_we_q   <= 1'b0;
      sd_data_q <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      sd_addr_q <= sd_addr_d;
      sd_we_q   <= sd_we_d;
      sd_data_q <= sd_data_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      busy_q    <= busy_d;
    end
  end

  assign r0_ack    = ack0_q;
  assign r1_ack    = ack1_q;
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;
  assign sd_addr   = sd_addr_q;
  assign sd_we     = sd_we_q;
  assign sd_data_o = sd_data_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
